// File: rtl/raxm_mul_arbiter.sv
// Round-robin arbiter sharing one approximate multiplier between two
// requesters, with completion timeout and a count of successful operations.
module raxm_mul_arbiter #(
    parameter int W       = 16,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic             r0_valid_i,
    output logic             r0_ready_o,
    input  logic [W-1:0]     r0_a_i,
    input  logic [W-1:0]     r0_b_i,
    output logic             r0_resp_o,
    output logic             r0_err_o,
    output logic [2*W-1:0]   r0_prod_o,

    input  logic             r1_valid_i,
    output logic             r1_ready_o,
    input  logic [W-1:0]     r1_a_i,
    input  logic [W-1:0]     r1_b_i,
    output logic             r1_resp_o,
    output logic             r1_err_o,
    output logic [2*W-1:0]   r1_prod_o,

    output logic             mul_start_o,
    output logic [W-1:0]     mul_a_o,
    output logic [W-1:0]     mul_b_o,
    input  logic             mul_done_i,
    input  logic [2*W-1:0]   mul_prod_i,

    output logic             busy_o,
    output logic             owner_o,
    output logic [CNT_W-1:0] op_count_o
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    logic           last_grant;
    logic [TW-1:0]  tmo_cnt;
    logic           grant_ok;
    logic           grant;
    logic           finish;
    logic [2*W-1:0] res_prod;

    // Grant is decided combinationally so a waiting requester sees ready
    // in the same cycle it raises valid.
    always_comb begin
        grant_ok = (state == IDLE) && !wb_rst_i
                   && (r0_valid_i || r1_valid_i);
        grant = 1'b0;
        unique case ({r1_valid_i, r0_valid_i})
            2'b11:   grant = ~last_grant;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    assign r0_ready_o = grant_ok && !grant;
    assign r1_ready_o = grant_ok && grant;

    assign finish   = mul_done_i || (tmo_cnt == TMO_LAST);
    assign res_prod = mul_done_i ? mul_prod_i : '0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            tmo_cnt     <= '0;
            owner_o     <= 1'b0;
            busy_o      <= 1'b0;
            mul_start_o <= 1'b0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
            r0_resp_o   <= 1'b0;
            r0_err_o    <= 1'b0;
            r0_prod_o   <= '0;
            r1_resp_o   <= 1'b0;
            r1_err_o    <= 1'b0;
            r1_prod_o   <= '0;
            op_count_o  <= '0;
        end else begin
            mul_start_o <= 1'b0;
            r0_resp_o   <= 1'b0;
            r1_resp_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_ok) begin
                        mul_a_o     <= grant ? r1_a_i : r0_a_i;
                        mul_b_o     <= grant ? r1_b_i : r0_b_i;
                        owner_o     <= grant;
                        last_grant  <= grant;
                        mul_start_o <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (finish) begin
                        // done takes priority over an expiring timeout
                        if (owner_o) begin
                            r1_resp_o <= 1'b1;
                            r1_err_o  <= !mul_done_i;
                            r1_prod_o <= res_prod;
                        end else begin
                            r0_resp_o <= 1'b1;
                            r0_err_o  <= !mul_done_i;
                            r0_prod_o <= res_prod;
                        end
                        if (mul_done_i) begin
                            op_count_o <= op_count_o + 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
